// File: rtl/pcd_pkg.sv
// Shared types, default timing and the pause-window decode for the PCD pause_n sequencer.
package pcd_pkg;

   typedef enum logic [1:0] {SeqX, SeqY, SeqZ} seq_t;

   typedef enum logic [2:0] {StIdle, StSoc, StData, StEoc0, StEocy} state_t;

   localparam int unsigned DefClksPerBit = 128;
   localparam int unsigned DefPauseLen   = 32;

   // True when the given sequence holds the carrier paused at this point of the bit period.
   function automatic logic pause_low(input seq_t        seq,
                                      input int unsigned cnt,
                                      input int unsigned clks_per_bit,
                                      input int unsigned pause_len);
      logic low;
      low = 1'b0;
      unique case (seq)
         SeqZ:    low = (cnt < pause_len);
         SeqX:    low = (cnt >= clks_per_bit / 2) && (cnt < clks_per_bit / 2 + pause_len);
         default: low = 1'b0;
      endcase
      return low;
   endfunction

endpackage

// File: rtl/pcd_bit_timer.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module pcd_bit_timer #(
   parameter  int unsigned CLKS_PER_BIT = 128,
   localparam int unsigned CntW         = $clog2(CLKS_PER_BIT)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clear,
   output logic [CntW-1:0] cnt,
   output logic            period_end
);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign period_end = (cnt_q == CntW'(CLKS_PER_BIT - 1));
   assign cnt        = cnt_q;

   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (clear || period_end) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pcd_pause_n_sequencer.sv
// Modified-Miller (ISO 14443A, 106 kbps) encoder driving the PCD pause_n line from frame bits.
module pcd_pause_n_sequencer
   import pcd_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DefClksPerBit,
   parameter int unsigned PAUSE_LEN    = DefPauseLen
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_valid,
   input  logic in_data,
   input  logic in_last,
   output logic in_ready,
   output logic pcd_pause_n,
   output logic busy,
   output logic underrun
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

   state_t          state_q, state_d;
   logic            bit_q, bit_d;
   logic            last_q, last_d;
   logic            prev_q, prev_d;
   logic            pause_q, pause_d;
   logic [CntW-1:0] cnt;
   logic            period_end;
   logic            timer_clear;
   seq_t            seq;

   assign timer_clear = (state_q == StIdle);

   pcd_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (timer_clear),
      .cnt        (cnt),
      .period_end (period_end)
   );

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      last_d   = last_q;
      prev_d   = prev_q;
      in_ready = 1'b0;
      underrun = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               state_d = StSoc;
               prev_d  = 1'b0;
            end
         end
         StSoc: begin
            if (period_end) begin
               in_ready = 1'b1;
               prev_d   = 1'b0;
               if (in_valid) begin
                  bit_d   = in_data;
                  last_d  = in_last;
                  state_d = StData;
               end else begin
                  underrun = 1'b1;
                  state_d  = StEoc0;
               end
            end
         end
         StData: begin
            if (period_end) begin
               prev_d = bit_q;
               if (last_q) begin
                  state_d = StEoc0;
               end else begin
                  in_ready = 1'b1;
                  if (in_valid) begin
                     bit_d   = in_data;
                     last_d  = in_last;
                     state_d = StData;
                  end else begin
                     // Source ran dry mid-frame: close the frame rather than stall the carrier.
                     underrun = 1'b1;
                     state_d  = StEoc0;
                  end
               end
            end
         end
         StEoc0: begin
            if (period_end) begin
               state_d = StEocy;
            end
         end
         StEocy: begin
            if (period_end) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // A logic 0 after a logic 1 must be Y so no two pauses sit closer than a half period.
   always_comb begin
      seq = SeqY;
      unique case (state_q)
         StSoc:   seq = SeqZ;
         StData:  seq = bit_q ? SeqX : (prev_q ? SeqY : SeqZ);
         StEoc0:  seq = prev_q ? SeqY : SeqZ;
         default: seq = SeqY;
      endcase
   end

   assign pause_d     = ~pause_low(seq, 32'(cnt), CLKS_PER_BIT, PAUSE_LEN);
   assign pcd_pause_n = pause_q;
   assign busy        = (state_q != StIdle);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         bit_q   <= 1'b0;
         last_q  <= 1'b0;
         prev_q  <= 1'b0;
         pause_q <= 1'b1;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         last_q  <= last_d;
         prev_q  <= prev_d;
         pause_q <= pause_d;
      end
   end

endmodule

// File: tb/tb_pcd_pause_n_sequencer.sv
// Self-checking bench: directed and random frames compared against a per-bit-period waveform model.
module tb_pcd_pause_n_sequencer;

   localparam int Cpb  = 128;
   localparam int Plen = 32;
   localparam int SX   = 0;
   localparam int SY   = 1;
   localparam int SZ   = 2;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic in_valid = 1'b0;
   logic in_data  = 1'b0;
   logic in_last  = 1'b0;
   logic in_ready, pcd_pause_n, busy, underrun;

   int   tests = 0;
   int   fails = 0;
   logic dq[$];
   logic lq[$];
   int   idx = 0;
   int   supply_end = 0;

   pcd_pause_n_sequencer #(
      .CLKS_PER_BIT (Cpb),
      .PAUSE_LEN    (Plen)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .pcd_pause_n (pcd_pause_n),
      .busy        (busy),
      .underrun    (underrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic is_low(input int s, input int k);
      return (s == SZ && k < Plen) || (s == SX && k >= Cpb / 2 && k < Cpb / 2 + Plen);
   endfunction

   task automatic present();
      if (idx < supply_end) begin
         in_valid = 1'b1;
         in_data  = dq[idx];
         in_last  = lq[idx];
      end else begin
         in_valid = 1'b0;
         in_data  = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   // Queue nbits bits (bit i of pat); a truncated frame never marks a last bit.
   task automatic add_frame(input logic [15:0] pat, input int nbits, input logic trunc,
                            output int first);
      first = dq.size();
      for (int i = 0; i < nbits; i++) begin
         dq.push_back(pat[i]);
         lq.push_back(!trunc && i == nbits - 1);
      end
      supply_end = dq.size();
   endtask

   // Next posedge must be the one sampling in_valid in IDLE; returns at the first IDLE cycle.
   task automatic run_frame(input int first, input int nbits, input logic trunc);
      int   elems[$];
      int   prev;
      int   len;
      int   e;
      int   k;
      logic exp_p;
      logic consumed;
      elems.push_back(SZ);
      prev = 0;
      for (int i = 0; i < nbits; i++) begin
         if (dq[first + i]) begin
            elems.push_back(SX);
            prev = 1;
         end else begin
            elems.push_back(prev != 0 ? SY : SZ);
            prev = 0;
         end
      end
      elems.push_back(prev != 0 ? SY : SZ);
      elems.push_back(SY);
      len = elems.size() * Cpb;
      @(posedge clk);
      #1;
      for (int c = 0; c <= len; c++) begin
         @(negedge clk);
         e = c / Cpb;
         k = c % Cpb;
         exp_p = 1'b1;
         if (c > 0) exp_p = !is_low(elems[(c - 1) / Cpb], (c - 1) % Cpb);
         check("pause_n", pcd_pause_n, exp_p);
         check("busy", busy, c < len);
         check("in_ready", in_ready,
               (c < len) && k == Cpb - 1 && (e < nbits || (trunc && e == nbits)));
         check("underrun", underrun, (c < len) && k == Cpb - 1 && trunc && e == nbits);
         if (c < len) begin
            consumed = in_ready && in_valid;
            @(posedge clk);
            #1;
            if (consumed) idx++;
            present();
         end
      end
   endtask

   initial begin
      int first;
      int first_b;
      int nb;
      int nb_b;
      logic tr;
      logic [15:0] pat;

      #12;
      check("reset pause_n", pcd_pause_n, 1'b1);
      check("reset in_ready", in_ready, 1'b0);
      check("reset busy", busy, 1'b0);
      check("reset underrun", underrun, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle busy", busy, 1'b0);

      // Directed frames: {1}, {0}, {1,0,0,1}, truncated {1,1}.
      add_frame(16'h0001, 1, 1'b0, first);
      present();
      run_frame(first, 1, 1'b0);
      add_frame(16'h0000, 1, 1'b0, first);
      present();
      run_frame(first, 1, 1'b0);
      add_frame(16'h0009, 4, 1'b0, first);
      present();
      run_frame(first, 4, 1'b0);
      add_frame(16'h0003, 2, 1'b1, first);
      present();
      run_frame(first, 2, 1'b1);

      for (int r = 0; r < 6; r++) begin
         repeat ($urandom_range(1, 4)) @(posedge clk);
         #1;
         nb  = $urandom_range(1, 8);
         pat = 16'($urandom);
         tr  = ($urandom_range(0, 3) == 0);
         add_frame(pat, nb, tr, first);
         present();
         run_frame(first, nb, tr);
      end

      // Back-to-back: second frame's first bit is already waiting when the first frame ends.
      @(posedge clk);
      #1;
      nb   = $urandom_range(1, 6);
      nb_b = $urandom_range(1, 6);
      add_frame(16'($urandom), nb, 1'b0, first);
      add_frame(16'($urandom), nb_b, 1'b0, first_b);
      present();
      run_frame(first, nb, 1'b0);
      check("b2b in_valid held", in_valid, 1'b1);
      run_frame(first_b, nb_b, 1'b0);

      // Reset in the middle of the SOC pause.
      @(posedge clk);
      #1;
      add_frame(16'h0001, 1, 1'b0, first);
      present();
      @(posedge clk);
      repeat (10) @(posedge clk);
      #2;
      check("pre-reset pause_n", pcd_pause_n, 1'b0);
      rst_n = 1'b0;
      #1;
      check("async reset pause_n", pcd_pause_n, 1'b1);
      check("async reset busy", busy, 1'b0);
      check("async reset in_ready", in_ready, 1'b0);
      idx = supply_end;
      present();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("post-reset pause_n", pcd_pause_n, 1'b1);
         check("post-reset busy", busy, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
